// File: rtl/apb_master.sv
// APB requester: accepts single read/write commands on a valid/ready port, runs the
// SETUP/ACCESS sequence and reports completion as a one-cycle response pulse.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response port
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              busy,
  // APB requester side
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic              pwrite_reg, pwrite_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_slverr_reg, rsp_slverr_next;
  logic              rsp_timeout_reg, rsp_timeout_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;

  assign cmd_ready = (state_reg == IDLE) && presetn;

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    paddr_next       = paddr_reg;
    pwrite_next      = pwrite_reg;
    pwdata_next      = pwdata_reg;
    rsp_valid_next   = 1'b0;
    rsp_slverr_next  = 1'b0;
    rsp_timeout_next = 1'b0;
    rsp_rdata_next   = '0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_next  = SETUP;
          cnt_next    = '0;
          paddr_next  = cmd_addr;
          pwrite_next = cmd_write;
          pwdata_next = cmd_wdata;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_next      = IDLE;
          rsp_valid_next  = 1'b1;
          rsp_slverr_next = pslverr;
          rsp_rdata_next  = (!pwrite_reg && !pslverr) ? prdata : '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          // cnt_reg counts the wait cycles already spent, so this is the last allowed one
          if (TO_EN && (cnt_reg == CNT_LAST)) begin
            state_next       = IDLE;
            rsp_valid_next   = 1'b1;
            rsp_slverr_next  = 1'b1;
            rsp_timeout_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    psel_next    = (state_next == SETUP) || (state_next == ACCESS);
    penable_next = (state_next == ACCESS);
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      paddr_reg       <= '0;
      pwrite_reg      <= 1'b0;
      pwdata_reg      <= '0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_slverr_reg  <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      rsp_rdata_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      paddr_reg       <= paddr_next;
      pwrite_reg      <= pwrite_next;
      pwdata_reg      <= pwdata_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_slverr_reg  <= rsp_slverr_next;
      rsp_timeout_reg <= rsp_timeout_next;
      rsp_rdata_reg   <= rsp_rdata_next;
    end
  end

  assign paddr       = paddr_reg;
  assign pwrite      = pwrite_reg;
  assign pwdata      = pwdata_reg;
  assign psel        = psel_reg;
  assign penable     = penable_reg;
  assign busy        = psel_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_slverr  = rsp_slverr_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign rsp_rdata   = rsp_rdata_reg;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a 64-word APB RAM responder with programmable wait states,
// a vector table, reset/back-to-back sequences and random commands against a model.
module tb_apb_master;

  localparam int TIMEOUT = 16;

  logic        pclk;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // responder: words 0..63 exist, anything above errors; noise is driven outside ACCESS
  logic [31:0] mem [64];
  int          acc_cnt;
  int          wait_cfg;
  logic        dead;
  logic        clear_mem;

  always_comb begin
    if (!(psel && penable)) begin
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'hBAD0_BAD0;
    end else begin
      pready  = !dead && (acc_cnt >= wait_cfg);
      pslverr = (paddr >= 32'd64);
      prdata  = (paddr < 32'd64) ? mem[paddr[5:0]] : (32'hE000_0000 | paddr);
    end
  end

  always @(posedge pclk) begin
    acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
    if (clear_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (psel && penable && pready && pwrite && (paddr < 32'd64)) begin
      mem[paddr[5:0]] <= pwdata;
    end
  end

  int          n_checks;
  int          n_fail;
  logic [31:0] model_mem [64];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: outcome of one command from the RAM rules alone
  task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input int waits, output logic e_err, output logic e_to,
                         output logic [31:0] e_rd, output int e_lat);
    e_rd = 32'h0;
    if (waits < 0) begin
      e_err = 1'b1; e_to = 1'b1; e_lat = TIMEOUT + 2;
    end else if (addr >= 32'd64) begin
      e_err = 1'b1; e_to = 1'b0; e_lat = 3 + waits;
    end else begin
      e_err = 1'b0; e_to = 1'b0; e_lat = 3 + waits;
      if (wr) model_mem[addr[5:0]] = data;
      else    e_rd = model_mem[addr[5:0]];
    end
  endtask

  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input int waits, input logic e_err,
                         input logic e_to, input logic [31:0] e_rd, input int e_lat);
    int n;
    int lat;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    wait_cfg  = (waits < 0) ? 0 : waits;
    dead      = (waits < 0);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check({tag, " ready"}, 128'(cmd_ready), 128'(1'b1));
    @(negedge pclk);
    // scramble the command inputs so anything not latched at accept shows up
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~data;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      check({tag, " phase"}, {psel, penable, cmd_ready, pwrite, paddr, pwdata},
            {1'b1, (lat >= 2), 1'b0, wr, addr, data});
      @(negedge pclk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(e_lat));
    check({tag, " rsp"}, {rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata}, {1'b1, e_err, e_to, e_rd});
    check({tag, " idle"}, {psel, penable, cmd_ready}, 3'b001);
    @(negedge pclk);
    check({tag, " clear"}, {rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata, paddr, pwrite, pwdata},
          {3'b000, 32'h0, addr, wr, data});
    $display("txn %s wr=%0d addr=0x%0h waits=%0d -> lat=%0d slverr=%0d timeout=%0d rdata=0x%0h",
             tag, wr, addr, waits, lat, e_err, e_to, e_rd);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic        to;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t        vecs [13];
  logic        p_err, p_to, acc;
  logic [31:0] p_rd;
  int          p_lat, n, rsp_seen, idx, got, rises;
  logic        prev_psel;
  logic [31:0] train_exp [4];

  initial begin
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;

    vecs[0]  = '{1'b1, 32'h05, 32'hDEADBEEF,  0, 1'b0, 1'b0, 32'h0,        3};
    vecs[1]  = '{1'b0, 32'h05, 32'h0,         0, 1'b0, 1'b0, 32'hDEADBEEF, 3};
    vecs[2]  = '{1'b1, 32'h40, 32'h11112222,  0, 1'b1, 1'b0, 32'h0,        3};
    vecs[3]  = '{1'b0, 32'h40, 32'h0,         0, 1'b1, 1'b0, 32'h0,        3};
    vecs[4]  = '{1'b1, 32'h07, 32'h12345678,  3, 1'b0, 1'b0, 32'h0,        6};
    vecs[5]  = '{1'b0, 32'h07, 32'h0,         3, 1'b0, 1'b0, 32'h12345678, 6};
    vecs[6]  = '{1'b0, 32'h05, 32'h0,        -1, 1'b1, 1'b1, 32'h0,       18};
    vecs[7]  = '{1'b1, 32'h09, 32'hCAFEF00D,  0, 1'b0, 1'b0, 32'h0,        3};
    vecs[8]  = '{1'b0, 32'h09, 32'h0,         1, 1'b0, 1'b0, 32'hCAFEF00D, 4};
    vecs[9]  = '{1'b1, 32'h3F, 32'h0BADC0DE,  2, 1'b0, 1'b0, 32'h0,        5};
    vecs[10] = '{1'b0, 32'h3F, 32'h0,         0, 1'b0, 1'b0, 32'h0BADC0DE, 3};
    vecs[11] = '{1'b1, 32'h05, 32'h55555555, -1, 1'b1, 1'b1, 32'h0,       18};
    vecs[12] = '{1'b0, 32'h05, 32'h0,         0, 1'b0, 1'b0, 32'hDEADBEEF, 3};

    // reset with a pending command and the responder showing pready high
    presetn = 1'b0; clear_mem = 1'b1; dead = 1'b0; wait_cfg = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h123; cmd_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge pclk);
    check("reset outputs", {cmd_ready, psel, penable, rsp_valid, pready},
          5'b00001);
    check("reset regs", {paddr, pwdata, rsp_rdata, pwrite, rsp_slverr, rsp_timeout}, 99'h0);
    cmd_valid = 1'b0; clear_mem = 1'b0; presetn = 1'b1;
    @(negedge pclk);
    check("ready after reset", 128'(cmd_ready), 128'(1'b1));

    for (int i = 0; i < 13; i++) begin
      predict(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, p_err, p_to, p_rd, p_lat);
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
              vecs[i].err, vecs[i].to, vecs[i].rdata, vecs[i].lat);
    end

    // reset during ACCESS of a long read: the read must vanish without a response
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h05; wait_cfg = 10; dead = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check("abort in access", {psel, penable}, 2'b11);
    presetn = 1'b0;
    @(negedge pclk);
    check("abort drop", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
    @(negedge pclk);
    presetn = 1'b1;
    rsp_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge pclk);
      if (rsp_valid) rsp_seen++;
    end
    check("abort no rsp", 128'(rsp_seen), 128'(0));
    $display("txn abort read addr=0x5 -> responses seen=%0d", rsp_seen);
    predict(1'b0, 32'h05, 32'h0, 0, p_err, p_to, p_rd, p_lat);
    run_cmd("post-abort", 1'b0, 32'h05, 32'h0, 0, p_err, p_to, p_rd, p_lat);

    // back-to-back train with cmd_valid held high
    train_exp[0] = 32'h0; train_exp[1] = 32'h0;
    train_exp[2] = 32'hA5A5_0000; train_exp[3] = 32'hA5A5_0001;
    wait_cfg = 0; dead = 1'b0;
    idx = 0; got = 0; rises = 0; prev_psel = psel;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd10; cmd_wdata = 32'hA5A5_0000;
    for (int c = 0; c < 100 && got < 4; c++) begin
      acc = cmd_valid && cmd_ready;
      @(negedge pclk);
      if (psel && !prev_psel) rises++;
      prev_psel = psel;
      if (rsp_valid) begin
        check($sformatf("train rsp%0d", got), {rsp_slverr, rsp_timeout, rsp_rdata},
              {2'b00, train_exp[got]});
        $display("txn train%0d -> slverr=%0d rdata=0x%0h", got, rsp_slverr, rsp_rdata);
        got++;
      end
      if (acc) begin
        idx++;
        if (idx < 4) begin
          cmd_write = (idx < 2);
          cmd_addr  = 32'd10 + 32'(idx % 2);
          cmd_wdata = 32'hA5A5_0000 + 32'(idx);
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    check("train responses", 128'(got), 128'(4));
    check("train psel gaps", 128'(rises), 128'(4));
    model_mem[10] = 32'hA5A5_0000;
    model_mem[11] = 32'hA5A5_0001;
    @(negedge pclk);

    for (int i = 0; i < 40; i++) begin
      logic        r_wr;
      logic [31:0] r_addr, r_data;
      int          r_waits;
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 79));
      r_data  = $urandom;
      r_waits = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      predict(r_wr, r_addr, r_data, r_waits, p_err, p_to, p_rd, p_lat);
      run_cmd($sformatf("rnd%0d", i), r_wr, r_addr, r_data, r_waits, p_err, p_to, p_rd, p_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester driving the same `apb_if` signal set that the RAM responder consumes.
- Accepts single read/write commands on a valid/ready command port and sequences them through the APB SETUP and ACCESS phases.
- Returns read data and error status as a one-cycle response pulse.
- Bounds each transfer with a pready timeout, so a dead responder cannot hang the bench or the system.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr.
- DATA_W, 32, width of all data paths.
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready; 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- presetn  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clock edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_W  read data; 0 for writes, errors and timeouts.
- rsp_slverr  out  1  pslverr sampled at completion, or 1 on timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  high in SETUP and ACCESS.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- **Reset** (presetn == 0 at an edge):
  - state = IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_slverr, rsp_timeout all 0.
  - paddr, pwdata, rsp_rdata all 0; timeout counter 0.
  - Reset wins over every other event.
  - Reset mid-transfer: psel/penable drop at that edge, and no response is ever issued for the aborted command.
- **Outputs:** all are registered. cmd_ready = (state == IDLE) && presetn; it is the only combinational output.
- **IDLE:**
  - psel = 0, penable = 0.
  - On accept: latch cmd_addr, cmd_write and cmd_wdata into paddr, pwrite and pwdata; go to SETUP.
  - paddr, pwrite and pwdata hold their value outside transfers.
- **SETUP** (exactly one cycle):
  - psel = 1, penable = 0.
  - Next state is ACCESS.
- **ACCESS:**
  - psel = 1, penable = 1.
  - paddr, pwrite and pwdata are stable for the entire transfer.
  - pready sampled 1 at an edge:
    - Go to IDLE; psel and penable drop to 0.
    - rsp_valid = 1 for exactly one cycle.
    - rsp_slverr = pslverr, rsp_timeout = 0.
    - rsp_rdata = prdata if read && !pslverr, else 0.
  - pready sampled 0: increment the counter.
    - If TIMEOUT != 0 and counter == TIMEOUT-1: go to IDLE.
    - Pulse rsp_valid with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Counter clears on entry to SETUP.
- **Response fields:** rsp_slverr, rsp_timeout and rsp_rdata are valid only while rsp_valid = 1; they return to 0 the cycle after.
- **Latency:**
  - Accept at edge N → SETUP in cycle N+1 → ACCESS in cycle N+2.
  - With pready already high in the first ACCESS cycle, rsp_valid is high in cycle N+3.
  - Each wait state adds one cycle.
- **Throughput:**
  - One outstanding command.
  - cmd_ready is low from the accept edge until the cycle after completion.
  - The next command is accepted in the rsp_valid cycle at the earliest; psel is therefore low for at least one cycle between transfers.
- **Ignored inputs:** pready, pslverr and prdata are ignored outside ACCESS.
- **Illegal state encodings:** go to IDLE.

Test Plan:
- Reset with cmd_valid = 1 and pready = 1 → during reset, cmd_ready = 0, psel = 0, penable = 0, rsp_valid = 0. After presetn rises, cmd_ready = 1 on the next cycle.
- Write addr 0x05, data 0xDEADBEEF against the RAM responder, then read addr 0x05:
  - Write → psel high for SETUP+ACCESS; penable high only in ACCESS; pwdata stable; rsp_valid with rsp_slverr = 0.
  - Read → rsp_rdata = 0xDEADBEEF.
- Write addr 0x40 (64) → rsp_slverr = 1, rsp_timeout = 0. Read addr 0x40 → rsp_rdata = 0, rsp_slverr = 1.
- Responder model holding pready low for 3 ACCESS cycles → rsp_valid exactly 3 cycles after the minimum latency; paddr, pwrite and pwdata unchanged throughout.
- pready tied 0, TIMEOUT = 16 → exactly 16 ACCESS cycles, then psel = 0, rsp_valid = 1, rsp_slverr = 1, rsp_timeout = 1. A subsequent command is accepted normally.
- presetn asserted during ACCESS of a read → psel = 0 after that edge, no rsp_valid ever for that read. A back-to-back command train with cmd_valid held high issues 4 transfers, with psel low ≥1 cycle between them.
